// File: rtl/pulse_transmitter_pkg.sv
// Shared widths, symbol layout and sequencer state type for the pulse transmitter.
package pulse_transmitter_pkg;
  localparam int PT_NUM_SYMBOLS = 8;
  localparam int PT_DURATION_W  = 8;
  localparam int PT_LOOP_W      = 4;
  localparam int PT_PRESCALE_W  = 4;

  localparam int SYM_ADDR_W    = $clog2(PT_NUM_SYMBOLS);
  // A symbol word is {level, duration}; the level sits just above the duration field.
  localparam int SYM_W         = PT_DURATION_W + 1;
  localparam int SYM_LEVEL_BIT = PT_DURATION_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/pulse_transmitter_tick_gen.sv
// Loadable prescaler: emits one tick every (period+1) enabled cycles.
module pulse_transmitter_tick_gen #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_period,
  output logic         o_tick
);
  logic [W-1:0] r_period;
  logic [W-1:0] r_cnt;

  // The period is captured on load so later changes to i_period do not disturb a run.
  assign o_tick = i_en && !i_load && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_period <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_period <= i_period;
      r_cnt    <= i_period;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? r_period : r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/pulse_transmitter_sequencer.sv
// Plays a list of (level, duration) symbols on pulse_out, repeated cfg_loops+1 times.
module pulse_transmitter_sequencer
  import pulse_transmitter_pkg::*;
#(
  parameter int NUM_SYMBOLS = PT_NUM_SYMBOLS,
  parameter int DURATION_W  = PT_DURATION_W,
  parameter int LOOP_W      = PT_LOOP_W,
  parameter int PRESCALE_W  = PT_PRESCALE_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // start/stop are single-cycle strobes; stop always wins, start is only honoured in IDLE.
  input  logic                           start,
  input  logic                           stop,
  input  logic [$clog2(NUM_SYMBOLS)-1:0] cfg_last_sym,
  input  logic [LOOP_W-1:0]              cfg_loops,
  input  logic [PRESCALE_W-1:0]          cfg_prescale,
  input  logic                           cfg_idle_level,
  input  logic                           sym_wr_en,
  input  logic [$clog2(NUM_SYMBOLS)-1:0] sym_wr_addr,
  input  logic [DURATION_W:0]            sym_wr_data,
  output logic                           pulse_out,
  output logic                           busy,
  output logic                           done,
  output state_t                         dbg_state
);
  localparam int AW  = $clog2(NUM_SYMBOLS);
  localparam int LVL = DURATION_W;

  logic [DURATION_W:0]   r_mem [NUM_SYMBOLS];
  state_t                r_state;
  state_t                w_state_nxt;
  logic [AW-1:0]         r_ptr;
  logic [AW-1:0]         r_last;
  logic [LOOP_W-1:0]     r_loop;
  logic [LOOP_W-1:0]     r_loops;
  logic [DURATION_W-1:0] r_dur;
  logic                  r_idle;
  logic                  r_pulse;
  logic                  r_done;

  logic                  w_tick;
  logic                  w_start_ok;
  logic                  w_sym_end;
  logic                  w_final;
  logic                  w_pulse_nxt;
  logic                  w_done_nxt;
  logic [AW-1:0]         w_next_addr;
  logic [DURATION_W:0]   w_next_sym;
  logic [DURATION_W:0]   w_sym0;

  assign w_start_ok  = (r_state == ST_IDLE) && start && !stop;
  assign w_sym_end   = (r_state == ST_RUN) && w_tick && (r_dur == '0);
  assign w_final     = (r_ptr == r_last) && (r_loop == r_loops);
  assign w_next_addr = (r_ptr == r_last) ? {AW{1'b0}} : r_ptr + 1'b1;
  // Reads see the array before this cycle's write, so a same-cycle rewrite loads the old word.
  assign w_next_sym  = r_mem[w_next_addr];
  assign w_sym0      = r_mem[{AW{1'b0}}];

  pulse_transmitter_tick_gen #(.W(PRESCALE_W)) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_start_ok),
    .i_en     (r_state == ST_RUN),
    .i_period (cfg_prescale),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (sym_wr_en) r_mem[sym_wr_addr] <= sym_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_last  <= '0;
      r_loop  <= '0;
      r_loops <= '0;
      r_dur   <= '0;
      r_idle  <= 1'b0;
      r_pulse <= cfg_idle_level;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pulse <= w_pulse_nxt;
      r_done  <= w_done_nxt;
      if (w_start_ok) begin
        r_last  <= cfg_last_sym;
        r_loops <= cfg_loops;
        r_idle  <= cfg_idle_level;
        r_ptr   <= '0;
        r_loop  <= '0;
        r_dur   <= w_sym0[DURATION_W-1:0];
      end else if ((r_state == ST_RUN) && !stop && w_tick) begin
        if (r_dur != '0) begin
          r_dur <= r_dur - 1'b1;
        end else if (!w_final) begin
          r_ptr <= w_next_addr;
          r_dur <= w_next_sym[DURATION_W-1:0];
          if (r_ptr == r_last) r_loop <= r_loop + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_nxt = ST_RUN;
      ST_RUN:  if (stop || (w_sym_end && w_final)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pulse_nxt = r_pulse;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: w_pulse_nxt = w_start_ok ? w_sym0[LVL] : cfg_idle_level;
      ST_RUN: begin
        if (stop) begin
          w_pulse_nxt = r_idle;
        end else if (w_sym_end) begin
          if (w_final) begin
            w_pulse_nxt = r_idle;
            w_done_nxt  = 1'b1;
          end else begin
            w_pulse_nxt = w_next_sym[LVL];
          end
        end
      end
      default: w_pulse_nxt = r_idle;
    endcase
  end

  assign pulse_out = r_pulse;
  assign busy      = (r_state == ST_RUN);
  assign done      = r_done;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_pulse_transmitter_sequencer.sv
// Bench for pulse_transmitter_sequencer: symbol-level reference model, per-cycle compare, directed and random runs.
module tb_pulse_transmitter_sequencer;
  import pulse_transmitter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [2:0] cfg_last_sym;
  logic [3:0] cfg_loops;
  logic [3:0] cfg_prescale;
  logic       cfg_idle_level;
  logic       sym_wr_en;
  logic [2:0] sym_wr_addr;
  logic [8:0] sym_wr_data;
  logic       pulse_out;
  logic       busy;
  logic       done;
  state_t     dbg_state;

  pulse_transmitter_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .cfg_last_sym   (cfg_last_sym),
    .cfg_loops      (cfg_loops),
    .cfg_prescale   (cfg_prescale),
    .cfg_idle_level (cfg_idle_level),
    .sym_wr_en      (sym_wr_en),
    .sym_wr_addr    (sym_wr_addr),
    .sym_wr_data    (sym_wr_data),
    .pulse_out      (pulse_out),
    .busy           (busy),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_busy = 0;
  int cnt_high = 0;
  int cnt_done = 0;

  // reference model: whole-symbol cycle budgets, applied one clock at a time
  logic [8:0] m_mem [8];
  logic [3:0] exp_q [$];
  bit m_run = 0;
  bit m_pulse = 0, m_busy = 0, m_done = 0, m_idle = 0;
  int m_ptr, m_pass, m_rem, m_last, m_loops, m_pre;

  function automatic int sym_cycles(logic [8:0] s, int p);
    return (int'(s[7:0]) + 1) * (p + 1);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_busy = 0; m_done = 0; m_pulse = cfg_idle_level;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start && !stop) begin
          m_last = int'(cfg_last_sym); m_loops = int'(cfg_loops);
          m_pre = int'(cfg_prescale); m_idle = cfg_idle_level;
          m_ptr = 0; m_pass = 0;
          m_pulse = m_mem[0][8]; m_rem = sym_cycles(m_mem[0], m_pre);
          m_run = 1; m_busy = 1;
        end else begin
          m_pulse = cfg_idle_level;
        end
      end else if (stop) begin
        m_run = 0; m_busy = 0; m_pulse = m_idle;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_ptr < m_last) begin
            m_ptr++;
          end else if (m_pass < m_loops) begin
            m_pass++; m_ptr = 0;
          end else begin
            m_run = 0; m_busy = 0; m_pulse = m_idle; m_done = 1;
          end
          if (m_run) begin
            m_pulse = m_mem[m_ptr][8]; m_rem = sym_cycles(m_mem[m_ptr], m_pre);
          end
        end
      end
    end
    if (sym_wr_en) m_mem[sym_wr_addr] = sym_wr_data;
    exp_q.push_back({m_pulse, m_busy, m_done, m_busy});
  end

  // scoreboard: {pulse_out, busy, done, state==RUN} every cycle
  always @(negedge clk) begin
    logic [3:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pulse_out, busy, done, dbg_state == ST_RUN};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t got {pulse,busy,done,run}=%b want %b", $time, a, e);
      end
    end
    if (busy) cnt_busy++;
    if (busy && pulse_out) cnt_high++;
    if (done) cnt_done++;
  end

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic write_sym(int addr, bit lvl, int dur);
    @(posedge clk); #1;
    sym_wr_en = 1'b1; sym_wr_addr = 3'(addr); sym_wr_data = {lvl, 8'(dur)};
    @(posedge clk); #1 sym_wr_en = 1'b0;
  endtask

  task automatic set_cfg(int n, int l, int p, bit idle);
    cfg_last_sym = 3'(n); cfg_loops = 4'(l); cfg_prescale = 4'(p); cfg_idle_level = idle;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_stop();
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    n_cmp++;
    if (k == budget) begin
      n_err++;
      $display("FAIL wait_idle got busy after %0d cycles want idle", budget);
    end
    repeat (2) @(negedge clk);
  endtask

  int b0, h0, d0;
  task automatic snap();
    b0 = cnt_busy; h0 = cnt_high; d0 = cnt_done;
  endtask
  task automatic check_counts(string tag, int eb, int eh, int ed);
    check({tag, "_busy_cycles"}, cnt_busy - b0, eb);
    check({tag, "_high_cycles"}, cnt_high - h0, eh);
    check({tag, "_done_pulses"}, cnt_done - d0, ed);
  endtask

  task automatic load_random_syms(int max_dur);
    for (int i = 0; i < 8; i++) write_sym(i, 1'($urandom_range(0, 1)), $urandom_range(0, max_dur));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; sym_wr_en = 1'b0;
    sym_wr_addr = '0; sym_wr_data = '0;
    set_cfg(0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_pulse", int'(pulse_out), 0);
    #1 rst_n = 1'b1;

    // two symbols, no prescale
    write_sym(0, 1'b1, 2);
    write_sym(1, 1'b0, 0);
    set_cfg(1, 0, 0, 1'b0);
    snap(); do_start(); wait_idle(200);
    check_counts("basic", 4, 3, 1);

    // same symbols, prescale 3
    set_cfg(1, 0, 3, 1'b0);
    snap(); do_start(); wait_idle(200);
    check_counts("prescale", 16, 12, 1);

    // single symbol looped three times
    write_sym(0, 1'b1, 1);
    set_cfg(0, 2, 0, 1'b0);
    snap(); do_start(); wait_idle(200);
    check_counts("loops", 6, 6, 1);

    // long run, ignored restart with changed config, then abort
    load_random_syms(15);
    set_cfg(7, 3, 2, 1'b1);
    snap(); do_start();
    repeat (30) @(posedge clk);
    #1 set_cfg(0, 0, 0, 1'b0);
    do_start();
    repeat (10) @(posedge clk);
    do_stop();
    @(negedge clk);
    check("stop_busy", int'(busy), 0);
    check("stop_pulse_idle", int'(pulse_out), 1);
    repeat (3) @(negedge clk);
    check("stop_done_pulses", cnt_done - d0, 0);

    // start and stop together in IDLE
    snap();
    @(posedge clk); #1 begin start = 1'b1; stop = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; stop = 1'b0; end
    repeat (4) @(negedge clk);
    check("start_stop_busy", cnt_busy - b0, 0);

    // reset mid-run, then replay from the start
    set_cfg(7, 3, 1, 1'b0);
    snap(); do_start();
    repeat (20) @(posedge clk);
    do_reset();
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done_pulses", cnt_done - d0, 0);
    do_start(); wait_idle(5000);

    // config change and rewrite of the playing symbol mid-run
    write_sym(0, 1'b1, 5);
    write_sym(1, 1'b0, 3);
    set_cfg(1, 1, 1, 1'b0);
    snap(); do_start();
    repeat (3) @(posedge clk);
    #1 cfg_prescale = 4'd0;
    write_sym(0, 1'b0, 1);
    wait_idle(500);
    check_counts("rewrite", 32, 12, 1);

    // randomized runs, some aborted
    for (int it = 0; it < 10; it++) begin
      load_random_syms(7);
      set_cfg($urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
      do_start();
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 40)) @(posedge clk);
        do_stop();
      end
      wait_idle(2000);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
